cla_byte_serial_adder_ctrl: RTL and testbench
=============================================

# cla_byte_serial_adder_ctrl

Controller that time-shares one 8-bit carry-look-ahead adder to perform NBYTES-wide add/subtract, one byte per cycle, LSB first. The byte carry is registered between cycles. Operands are accepted and results returned over valid/ready handshakes. The block sits between the lab's operand source (register file or testbench driver) and any consumer that needs results wider than 8 bits without instantiating a wide adder.

## Interface
- NBYTES, 4, operand width in bytes (≥1); W = 8*NBYTES
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  W  operand A, sampled on input handshake
- b  input  W  operand B, sampled on input handshake
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1: compute a − b (b inverted, carry-in forced 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  W  result, stable while out_valid
- cout  output  1  final carry out of MSB byte (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b^{W{sub}}, carry = sub ? 1 : cin, clear byte index k=0 → RUN.
- RUN: drive byte k of A and B' plus carry register into the adder. Each cycle write adder sum into sum[8k+:8], carry ← adder c8, k ← k+1. On k==NBYTES−1, the same edge → DONE.
- DONE: out_valid=1, cout = carry register. ovf = (A[W−1]==B'[W−1]) && (sum[W−1]!=A[W−1]). On out_ready → IDLE. With out_ready low, hold all outputs unchanged.
- Width rules: k is $clog2(NBYTES) bits, min 1. Results wrap modulo 2^W. Unused cin under sub has no effect.
- Reset mid-operation (RUN or DONE): abort. Next cycle is IDLE with all outputs at reset values and latched operands discarded.
- in_valid while RUN/DONE: ignored, not queued; in_ready=0.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset values: in_ready=1 (after reset edge), out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- Input handshake at edge T. RUN occupies edges T+1 … T+NBYTES. out_valid=1 in the cycle after edge T+NBYTES.
- Latency from accept to out_valid is NBYTES+1 cycles (5 for NBYTES=4).
- Output handshake at edge D → in_ready=1 in the next cycle. Minimum initiation interval is NBYTES+2 cycles.
- Adder path is combinational within one cycle. The carry register breaks the ripple between bytes.
- NBYTES=1: single RUN cycle, latency 2.

## Structure
- Shared package `cla_ctrl_pkg`: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the byte-width constant 8.
- One sub-module: the team's existing 8-bit CLA (`Carry_Look_Ahead_Adder_8bit`: a, b, c0 → s, c8), instantiated once. No other arithmetic is inferred; byte muxing and sum write-back are plain logic.
- Internal registers: state, k, carry, opA, opB', sum, ovf.

## Test plan
- Add, NBYTES=4: a=0x0000_00FF, b=0x0000_0001, cin=0 → out_valid exactly 5 cycles after accept, sum=0x0000_0100, cout=0, ovf=0 (checks byte-carry chaining).
- Wrap and carry: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, ovf=0.
- Subtract and overflow: sub=1, a=0x8000_0000, b=0x0000_0001 → sum=0x7FFF_FFFF, cout=1, ovf=1. Then sub=1, a=3, b=5 → sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → sum/cout/ovf stable, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → IDLE next cycle and the following request is accepted normally.
- Reset mid-RUN: assert rst on the 2nd RUN cycle → next cycle IDLE, out_valid=0, sum=0, in_ready=1. The subsequent add 1+1 yields 2.
- Back-to-back with out_ready tied high: 100 random a/b/sub/cin requests → each result matches a reference model, one result every 6 cycles.

Source files
------------

// File: rtl/cla_byte_serial_adder_ctrl_pkg.sv
// Shared constants for the byte-serial CLA add/subtract controller.
package cla_ctrl_pkg;
   localparam int BYTE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/cla_byte_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the byte-serial adder controller.
interface cla_byte_serial_adder_ctrl_if
   import cla_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) ();
   localparam int W = BYTE_W * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_byte_serial_adder_ctrl_cla8.sv
// 8-bit carry-look-ahead adder; every carry is expanded from g/p and c0 directly.
module Carry_Look_Ahead_Adder_8bit
   import cla_ctrl_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              c0,
   output logic [BYTE_W-1:0] s,
   output logic              c8
);
   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W:0]   c;
   logic              term;
   logic              acc;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0, no ripple through c[i]
   always_comb begin
      c    = '0;
      term = 1'b0;
      acc  = 1'b0;
      c[0] = c0;
      for (int i = 0; i < BYTE_W; i++) begin
         term = c0;
         for (int j = 0; j < BYTE_W; j++)
            if (j <= i) term = term & p[j];
         acc = term;
         for (int j = 0; j < BYTE_W; j++) begin
            if (j <= i) begin
               term = g[j];
               for (int m = 0; m < BYTE_W; m++)
                  if (m > j && m <= i) term = term & p[m];
               acc = acc | term;
            end
         end
         c[i+1] = acc;
      end
   end

   assign s  = p ^ c[BYTE_W-1:0];
   assign c8 = c[BYTE_W];
endmodule

// File: rtl/cla_byte_serial_adder_ctrl.sv
// Byte-serial NBYTES-wide add/subtract built on one shared 8-bit CLA, LSB byte first.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one byte per cycle through the CLA, carry held in carry_q
// DONE  | result presented, held until out_ready
module cla_byte_serial_adder_ctrl
   import cla_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input logic                        clk,
   input logic                        rst,
   cla_byte_serial_adder_ctrl_if.slave bus
);
   localparam int W  = BYTE_W * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic          carry_q;
   logic [W-1:0]  opa_q;
   logic [W-1:0]  opb_q;
   logic [W-1:0]  sum_q;
   logic          ovf_q;
   logic          in_ready_q;
   logic          out_valid_q;

   logic [BYTE_W-1:0] a_byte_d;
   logic [BYTE_W-1:0] b_byte_d;
   logic [BYTE_W-1:0] cla_s;
   logic              cla_c8;
   logic              last_d;

   always_comb begin
      a_byte_d = '0;
      b_byte_d = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (k_q == KW'(i)) begin
            a_byte_d = opa_q[i*BYTE_W +: BYTE_W];
            b_byte_d = opb_q[i*BYTE_W +: BYTE_W];
         end
      end
   end

   assign last_d = (k_q == KW'(NBYTES - 1));

   Carry_Look_Ahead_Adder_8bit u_cla (
      .a  (a_byte_d),
      .b  (b_byte_d),
      .c0 (carry_q),
      .s  (cla_s),
      .c8 (cla_c8)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         carry_q     <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  opa_q      <= bus.a;
                  opb_q      <= bus.b ^ {W{bus.sub}};
                  carry_q    <= bus.sub | bus.cin;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NBYTES; i++)
                  if (k_q == KW'(i)) sum_q[i*BYTE_W +: BYTE_W] <= cla_s;
               carry_q <= cla_c8;
               k_q     <= k_q + 1'b1;
               if (last_d) begin
                  // MSB byte is being written this edge, so take its sign from the adder
                  ovf_q       <= (opa_q[W-1] == opb_q[W-1]) && (cla_s[BYTE_W-1] != opa_q[W-1]);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = carry_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_byte_serial_adder_ctrl.sv
// Scoreboard bench for the byte-serial CLA controller (NBYTES=4).
module tb_cla_byte_serial_adder_ctrl;
   localparam int NB = 4;
   localparam int W  = 8 * NB;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cla_byte_serial_adder_ctrl_if #(.NBYTES(NB)) bus ();

   cla_byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   exp_t mon_e;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      return e;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   r;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      return mk(r[W-1:0], r[W], (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]));
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("sum",  bus.sum,  mon_e.sum);
            chk("cout", bus.cout, mon_e.cout);
            chk("ovf",  bus.ovf,  mon_e.ovf);
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input exp_t e, input bit push, output time t_acc);
      int n;
      n = 0;
      bus.a = a;
      bus.b = b;
      bus.cin = cin;
      bus.sub = sub;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      t_acc = $time;
      if (push) q.push_back(e);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.out_valid) chk("out_timeout", 0, 1);
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input exp_t e);
      time t;
      int  n;
      send(a, b, cin, sub, e, 1'b1, t);
      wait_valid(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      time  t, prev;
      int   n;
      logic [W-1:0] ra, rb;
      logic rc, rs;

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      prev = 0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum",       bus.sum, 0);
      chk("rst_cout",      bus.cout, 0);
      chk("rst_ovf",       bus.ovf, 0);
      rst = 1'b0;

      // byte-carry chaining and accept-to-valid latency
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0), 1'b1, t);
      chk("run_in_ready", bus.in_ready, 0);
      wait_valid(n);
      chk("latency", n + 1, 5);
      @(posedge clk);
      #1;
      chk("idle_in_ready", bus.in_ready, 1);

      run_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
      run_one(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));

      // backpressure: hold DONE for 10 cycles while poking in_valid
      bus.out_ready = 1'b0;
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, mk(32'h0000_000D, 1'b0, 1'b0), 1'b1, t);
      wait_valid(n);
      for (int i = 0; i < 10; i++) begin
         chk("bp_sum",       bus.sum, 32'h0000_000D);
         chk("bp_cout",      bus.cout, 0);
         chk("bp_ovf",       bus.ovf, 0);
         chk("bp_in_ready",  bus.in_ready, 0);
         chk("bp_out_valid", bus.out_valid, 1);
         bus.in_valid = i[0];
         bus.a = $urandom;
         bus.b = $urandom;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_ready", bus.in_ready, 1);
      chk("bp_release_valid", bus.out_valid, 0);
      run_one(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, mk(32'h0000_2345, 1'b0, 1'b0));

      // reset on the 2nd RUN cycle aborts the operation
      send(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, mk('0, 1'b0, 1'b0), 1'b0, t);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_in_ready",  bus.in_ready, 1);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_sum",       bus.sum, 0);
      chk("abort_cout",      bus.cout, 0);
      chk("abort_ovf",       bus.ovf, 0);
      run_one(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0));

      // back-to-back random traffic with out_ready tied high
      for (int i = 0; i < 100; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         if (i % 10 == 0) rb = ra;
         send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1, t);
         if (i > 0) chk("interval", (t - prev) / 10, 6);
         prev = t;
      end

      n = 0;
      while (q.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
